// File: rtl/ring_phase_monitor.sv
// Ring phase monitor: decodes a one-hot ring sample, checks rotation order, counts revolutions.
// Latency: 1 cycle from ring_in to every output (all outputs registered).
// Backpressure: none; one sample is consumed every clk.
module ring_phase_monitor #(
  parameter int WIDTH       = 4,
  parameter int DIR         = 0,
  parameter int ALLOW_HOLD  = 0,
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clear_err,
  output logic [IDX_W-1:0] phase_idx,
  output logic             phase_valid,
  output logic             locked,
  output logic             rev_pulse,
  output logic [CNT_W-1:0] rev_count,
  output logic             err_illegal,
  output logic             err_skip,
  output logic [7:0]       fault_count
);

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;
  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CYCLES);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_valid;
  logic             r_prev_legal;
  logic [7:0]       r_good_cnt;

  logic [IDX_W:0]   w_pop;
  logic [IDX_W-1:0] w_idx;
  logic             w_legal;
  logic [WIDTH-1:0] w_rot;
  logic             w_wrap_src;
  logic             w_step;
  logic             w_hold;
  logic             w_trans_ok;
  logic             w_rev;
  logic [7:0]       w_good_next;

  // Decode the current sample: population count and index of the set bit.
  always_comb begin
    w_pop = '0;
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + (IDX_W+1)'(ring_in[i]);
      if (ring_in[i]) w_idx = i[IDX_W-1:0];
    end
  end

  // Expected next pattern and the bit whose departure marks a completed revolution.
  always_comb begin
    if (DIR == 0) begin
      w_rot      = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
      w_wrap_src = r_prev[WIDTH-1];
    end else begin
      w_rot      = {r_prev[0], r_prev[WIDTH-1:1]};
      w_wrap_src = r_prev[0];
    end
  end

  // A step from a legal previous sample to its rotation is itself one-hot, so no
  // separate current-sample legality term is needed for the transition check.
  assign w_legal     = (w_pop == (IDX_W+1)'(1));
  assign w_step      = (ring_in == w_rot);
  assign w_hold      = (ALLOW_HOLD != 0) && (ring_in == r_prev);
  assign w_trans_ok  = r_prev_valid && r_prev_legal && (w_step || w_hold);
  assign w_rev       = w_trans_ok && w_step && w_wrap_src;
  assign w_good_next = r_good_cnt + 8'd1;

  // Sample history, phase decode outputs, lock FSM and fault bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_ACQUIRE;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_prev_legal <= 1'b0;
      r_good_cnt   <= '0;
      phase_idx    <= '0;
      phase_valid  <= 1'b0;
      locked       <= 1'b0;
      rev_pulse    <= 1'b0;
      rev_count    <= '0;
      err_illegal  <= 1'b0;
      err_skip     <= 1'b0;
      fault_count  <= '0;
    end else begin
      r_prev       <= ring_in;
      r_prev_legal <= w_legal;
      r_prev_valid <= 1'b1;
      rev_pulse    <= 1'b0;
      locked       <= 1'b0;
      phase_valid  <= w_legal;
      if (w_legal) phase_idx <= w_idx;
      // Flag clearing is overridden below when a fault is detected this cycle.
      if (clear_err) begin
        err_illegal <= 1'b0;
        err_skip    <= 1'b0;
      end
      case (r_state)
        ST_ACQUIRE: begin
          if (w_trans_ok) begin
            if (w_good_next == LOCK_TGT) begin
              r_state    <= ST_LOCKED;
              r_good_cnt <= '0;
              locked     <= 1'b1;
            end else begin
              r_good_cnt <= w_good_next;
            end
          end else begin
            r_good_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (!w_legal || !w_trans_ok) begin
            r_state <= ST_FAULT;
            if (!w_legal) err_illegal <= 1'b1;
            else          err_skip    <= 1'b1;
            if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
          end else begin
            locked <= 1'b1;
            if (w_rev) begin
              rev_pulse <= 1'b1;
              rev_count <= rev_count + CNT_W'(1);
            end
          end
        end
        ST_FAULT: begin
          // Leaving FAULT restarts acquisition: the sample at this edge is not
          // used as the reference for the next transition.
          if (clear_err) begin
            r_state      <= ST_ACQUIRE;
            r_good_cnt   <= '0;
            r_prev_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_ACQUIRE;
          r_good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
module tb_ring_phase_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ring = 4'b0000;
  logic        clr = 1'b0;
  logic [1:0]  a_idx;
  logic        a_pv, a_lk, a_rp, a_ei, a_es;
  logic [15:0] a_rc;
  logic [7:0]  a_fc;

  logic        h_reset = 1'b1;
  logic [3:0]  h_ring = 4'b0000;
  logic        h_clr = 1'b0;
  logic [1:0]  h_idx;
  logic        h_pv, h_lk, h_rp, h_ei, h_es;
  logic [15:0] h_rc;
  logic [7:0]  h_fc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ring_phase_monitor u_dut (
    .clk(clk), .reset(reset), .ring_in(ring), .clear_err(clr),
    .phase_idx(a_idx), .phase_valid(a_pv), .locked(a_lk), .rev_pulse(a_rp),
    .rev_count(a_rc), .err_illegal(a_ei), .err_skip(a_es), .fault_count(a_fc)
  );

  ring_phase_monitor #(.ALLOW_HOLD(1)) u_hold (
    .clk(clk), .reset(h_reset), .ring_in(h_ring), .clear_err(h_clr),
    .phase_idx(h_idx), .phase_valid(h_pv), .locked(h_lk), .rev_pulse(h_rp),
    .rev_count(h_rc), .err_illegal(h_ei), .err_skip(h_es), .fault_count(h_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample and clear_err, then sample outputs 1 time unit after the edge.
  task automatic tick(input logic [3:0] v, input logic c);
    ring = v;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_h(input logic [3:0] v);
    h_ring = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idx"}, 32'(a_idx), 0);
    chk({tag, "_pv"},  32'(a_pv), 0);
    chk({tag, "_lk"},  32'(a_lk), 0);
    chk({tag, "_rp"},  32'(a_rp), 0);
    chk({tag, "_rc"},  32'(a_rc), 0);
    chk({tag, "_ei"},  32'(a_ei), 0);
    chk({tag, "_es"},  32'(a_es), 0);
    chk({tag, "_fc"},  32'(a_fc), 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick(4'b0000, 1'b0);
    reset = 1'b0;
    chk_all_zero("rst");

    // 1. Lock-up with default parameters
    tick(4'b0001, 1'b0); chk("t1_idx0", 32'(a_idx), 0); chk("t1_pv", 32'(a_pv), 1);
    tick(4'b0010, 1'b0); chk("t1_idx1", 32'(a_idx), 1);
    tick(4'b0100, 1'b0); chk("t1_idx2", 32'(a_idx), 2);
    tick(4'b1000, 1'b0); chk("t1_idx3", 32'(a_idx), 3); chk("t1_nolock4", 32'(a_lk), 0);
    tick(4'b0001, 1'b0); chk("t1_idx0b", 32'(a_idx), 0); chk("t1_lock5", 32'(a_lk), 1);
    chk("t1_rc_at_lock", 32'(a_rc), 0); chk("t1_rp_at_lock", 32'(a_rp), 0);
    tick(4'b0010, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0); chk("t1_rp8", 32'(a_rp), 0);
    tick(4'b0001, 1'b0); chk("t1_rp9", 32'(a_rp), 1); chk("t1_rc9", 32'(a_rc), 1);
    tick(4'b0010, 1'b0); chk("t1_rp10", 32'(a_rp), 0); chk("t1_lk10", 32'(a_lk), 1);

    // 2. Illegal pattern in place of 0100
    tick(4'b0110, 1'b0);
    chk("t2_pv", 32'(a_pv), 0); chk("t2_lk", 32'(a_lk), 0);
    chk("t2_ei", 32'(a_ei), 1); chk("t2_es", 32'(a_es), 0);
    chk("t2_fc", 32'(a_fc), 1); chk("t2_idx_hold", 32'(a_idx), 1);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0);
    chk("t2_rc_frozen", 32'(a_rc), 1); chk("t2_rp_frozen", 32'(a_rp), 0);
    chk("t2_ei_held", 32'(a_ei), 1); chk("t2_lk_fault", 32'(a_lk), 0);

    // 4. Clear and re-acquire: lock returns 5 samples after the clear edge
    tick(4'b0010, 1'b1);
    chk("t4_ei_clr", 32'(a_ei), 0); chk("t4_lk_clr", 32'(a_lk), 0);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0); chk("t4_rc_acq", 32'(a_rc), 1); chk("t4_rp_acq", 32'(a_rp), 0);
    tick(4'b0010, 1'b0); chk("t4_nolock4", 32'(a_lk), 0);
    tick(4'b0100, 1'b0); chk("t4_lock5", 32'(a_lk), 1); chk("t4_fc", 32'(a_fc), 1);

    // 3. Skip while locked: 0001 then 0100
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0); chk("t3_rc2", 32'(a_rc), 2);
    tick(4'b0100, 1'b0);
    chk("t3_es", 32'(a_es), 1); chk("t3_ei", 32'(a_ei), 0); chk("t3_lk", 32'(a_lk), 0);
    chk("t3_fc", 32'(a_fc), 2); chk("t3_idx", 32'(a_idx), 2); chk("t3_pv", 32'(a_pv), 1);

    // Clear and relock
    tick(4'b1000, 1'b1); chk("t3_es_clr", 32'(a_es), 0);
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0); chk("t3_relock", 32'(a_lk), 1); chk("t3_rc_relock", 32'(a_rc), 2);

    // 5a. Hold with ALLOW_HOLD=0 is a skip
    tick(4'b0010, 1'b0); chk("t5_lk_pre", 32'(a_lk), 1);
    tick(4'b0010, 1'b0);
    chk("t5_es", 32'(a_es), 1); chk("t5_lk", 32'(a_lk), 0); chk("t5_fc", 32'(a_fc), 3);
    tick(4'b0100, 1'b1);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0); chk("t5_relock", 32'(a_lk), 1);

    // 6a. clear_err together with an illegal sample while locked: fault wins
    tick(4'b0000, 1'b1);
    chk("t6_ei", 32'(a_ei), 1); chk("t6_lk", 32'(a_lk), 0); chk("t6_fc", 32'(a_fc), 4);
    tick(4'b0001, 1'b1); chk("t6_ei_clr", 32'(a_ei), 0);
    tick(4'b0010, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0); chk("t6_relock", 32'(a_lk), 1); chk("t6_rc_pre", 32'(a_rc), 2);
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0); chk("t6_rc3", 32'(a_rc), 3);

    // 6b. Reset while locked discards everything
    reset = 1'b1;
    tick(4'b0010, 1'b0);
    reset = 1'b0;
    chk_all_zero("t6_rst");
    tick(4'b0100, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0010, 1'b0); chk("t6_nolock4", 32'(a_lk), 0);
    tick(4'b0100, 1'b0); chk("t6_lock5", 32'(a_lk), 1);

    // 5b. Hold with ALLOW_HOLD=1 stays locked, no revolution
    h_reset = 1'b1;
    tick_h(4'b0000);
    h_reset = 1'b0;
    tick_h(4'b0001);
    tick_h(4'b0010);
    tick_h(4'b0100);
    tick_h(4'b1000);
    tick_h(4'b0001); chk("h_lock", 32'(h_lk), 1);
    tick_h(4'b0010);
    tick_h(4'b0010);
    chk("h_hold_lk", 32'(h_lk), 1); chk("h_hold_rp", 32'(h_rp), 0); chk("h_hold_es", 32'(h_es), 0);
    tick_h(4'b0100);
    tick_h(4'b1000);
    tick_h(4'b1000); chk("h_hold8_rp", 32'(h_rp), 0); chk("h_hold8_rc", 32'(h_rc), 0);
    tick_h(4'b0001); chk("h_rev_rp", 32'(h_rp), 1); chk("h_rev_rc", 32'(h_rc), 1);
    chk("h_fc", 32'(h_fc), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the 4-bit one-hot ring counter output. It samples the ring pattern every clock, decodes the active phase to a binary index, and checks one-hot legality and rotation order. It counts full revolutions and reports sticky fault flags, so the control logic can gate on a verified "locked" sequence.

Parameters:
WIDTH, 4, ring width in bits; must be >= 2.
DIR, 0, expected rotation; 0 = toward MSB (0001->0010), 1 = toward LSB (0001->1000).
ALLOW_HOLD, 0, 1 = an unchanged pattern on consecutive samples is a legal transition.
LOCK_CYCLES, 4, consecutive legal transitions required to enter LOCKED; range 1..255.
CNT_W, 16, revolution counter width.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
ring_in  input  WIDTH  ring counter output (out), sampled every clk.
clear_err  input  1  clears sticky error flags; leaves FAULT.
phase_idx  output  $clog2(WIDTH)  index of the set bit in the last legal sample.
phase_valid  output  1  last sample was exactly one-hot.
locked  output  1  high in LOCKED state only.
rev_pulse  output  1  one-cycle pulse per completed revolution while LOCKED.
rev_count  output  CNT_W  revolutions counted while LOCKED; wraps mod 2^CNT_W.
err_illegal  output  1  sticky: non-one-hot sample seen while LOCKED.
err_skip  output  1  sticky: one-hot sample that is an out-of-order transition, seen while LOCKED.
fault_count  output  8  number of LOCKED->FAULT entries; saturates at 255.

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high. All outputs are registered. Outputs reflect the sample taken at the same edge (1-cycle latency from ring_in).
- Reset: state=ACQUIRE, prev_valid=0, good_cnt=0. All outputs are 0, including phase_idx, rev_count and fault_count. Reset mid-operation discards all history.
- Sample legality: legal if popcount(ring_in)==1.
  - Legal sample: phase_valid=1, phase_idx=bit index.
  - Otherwise: phase_valid=0, phase_idx holds.
- Transition legality: requires prev_valid=1, previous sample legal, and one of:
  - cur == rotate(prev, DIR);
  - ALLOW_HOLD=1 and cur==prev.
- First sample after reset or after clear_err: no transition check; it only loads prev.
- prev register: loaded with every sample. prev_valid=1 after the first sample.
- Revolution: a legal rotation from bit WIDTH-1 to bit 0 (DIR=0), or from bit 0 to bit WIDTH-1 (DIR=1). Holds never count.
- FSM ACQUIRE:
  - Legal transition: good_cnt+1. If good_cnt+1 == LOCK_CYCLES, go to LOCKED at that edge.
  - Illegal sample or illegal transition: good_cnt=0.
  - No error flags are raised.
  - Revolutions are not counted.
- FSM LOCKED:
  - Legal transition: stay. On a revolution, rev_pulse=1 for one cycle and rev_count+1.
  - Illegal sample: go to FAULT, err_illegal=1, fault_count+1.
  - Legal sample with illegal transition: go to FAULT, err_skip=1, fault_count+1.
- FSM FAULT:
  - locked=0; flags held.
  - clear_err=1: go to ACQUIRE, clear err_illegal and err_skip, good_cnt=0, prev_valid=0.
- clear_err outside FAULT: clears sticky flags only.
- Simultaneous events:
  - clear_err in the same cycle as a LOCKED fault detection: the fault wins (FAULT entered, flag set).
  - reset beats everything.
- fault_count is cleared only by reset.

Test Plan:
1. Lock-up, defaults:
   - Stimulus: reset 1 cycle, then ring_in = 0001,0010,0100,1000,0001,... one per clk.
   - Required: locked=1 after the 5th sampling edge (4 legal transitions). rev_count=0 at lock; rev_pulse on the sample-9 edge (1000->0001); rev_count=1.
   - Required: phase_idx tracks 0,1,2,3,0.
2. Illegal pattern while locked:
   - Stimulus: inject 0110 in place of 0100.
   - Required: next edge gives phase_valid=0, locked=0, err_illegal=1, err_skip=0, fault_count=1.
   - Required: rev_count frozen while in FAULT.
3. Skip while locked:
   - Stimulus: 0001 then 0100.
   - Required: err_skip=1, err_illegal=0, FAULT entered, fault_count increments by 1. phase_idx=2, phase_valid=1.
4. Clear and re-acquire:
   - Stimulus: from FAULT, pulse clear_err with clean rotation continuing.
   - Required: flags clear next edge. locked returns LOCK_CYCLES+1 samples after clear_err. fault_count is unchanged.
5. Hold handling:
   - Stimulus: ALLOW_HOLD=0 with 0010,0010 while locked.
   - Required: err_skip=1.
   - Stimulus: ALLOW_HOLD=1 with the same pattern.
   - Required: stays LOCKED, no rev_pulse.
6. Reset mid-operation plus simultaneous clear:
   - Stimulus: clear_err=1 in the same cycle as an illegal sample while LOCKED.
   - Required: FAULT with err_illegal=1.
   - Stimulus: reset while locked with rev_count=3.
   - Required: all outputs 0 next edge; re-lock requires the full LOCK_CYCLES.
